iter_shifter: RTL and testbench

Multi-cycle shift unit for the RISC5 execute stage, used by the low-area core variant in place of the single-cycle combinational shifters. It takes an operand, shift count and shift kind from the operand registers and produces the result on `y` for the register-file write mux. It follows the same run/stall handshake as the Multiplier: the core holds `run` and freezes while `stall` is high. Shifting is nibble-serial: the fine shift (0–3) happens at load, then one 4-bit step per cycle.

---
 rtl/iter_shifter.sv | 57 +++++
 tb/tb_iter_shifter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: nibble-serial LSL/ASR/ROR unit using the run/stall handshake.
// Define ITER_SHIFTER_ROR_EN to build rotate; without it, op 10 executes as ASR.
module iter_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [4:0]  sc,
    output logic        stall,
    output logic [31:0] y
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state;
    logic [31:0] r;
    logic [2:0]  cnt;
    logic [1:0]  opq;

    // Shift by 0..4; right shifts take their fill from the upper half of a 64-bit window
    function automatic logic [31:0] shr(input logic [1:0] o, input logic [31:0] v, input logic [2:0] n);
        logic        rot;
        logic        asr;
        logic [63:0] t;
`ifdef ITER_SHIFTER_ROR_EN
        rot = (o == 2'b10);
        asr = (o == 2'b01);
`else
        rot = 1'b0;
        asr = o[1] ^ o[0];
`endif
        t = {rot ? v : {32{asr & v[31]}}, v} >> n;
        return (rot | asr) ? t[31:0] : v << n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            cnt   <= '0;
            opq   <= '0;
        end else if (run && state != SHIFT) begin
            r     <= shr(op, x, {1'b0, sc[1:0]});
            cnt   <= sc[4:2];
            opq   <= op;
            state <= (sc[4:2] != 3'd0) ? SHIFT : DONE;
        end else if (state == SHIFT) begin
            r     <= shr(opq, r, 3'd4);
            cnt   <= cnt - 3'd1;
            state <= (cnt == 3'd1) ? DONE : SHIFT;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

    assign stall = run & (state != DONE) & ~rst;
    assign y     = r;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized and directed checks of iter_shifter against an arithmetic model.
module tb_iter_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] x = '0;
    logic [4:0]  sc = '0;
    logic        stall;
    logic [31:0] y;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last;

    iter_shifter dut (.clk(clk), .rst(rst), .run(run), .op(op), .x(x), .sc(sc), .stall(stall), .y(y));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input int s);
        logic signed [31:0] sv;
        sv = v;
`ifndef ITER_SHIFTER_ROR_EN
        if (o == 2'b10) o = 2'b01;
`endif
        if (o == 2'b01) return sv >>> s;
        if (o == 2'b10) return (s == 0) ? v : (v >> s) | (v << (32 - s));
        return v << s;
    endfunction

    // Called at a negedge; leaves run high with the DUT in DONE at a negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s, input bit from_idle);
        int n;
        bit done;
        n = 0;
        done = 0;
        op = o; x = v; sc = s; run = 1'b1;
        if (!from_idle) @(negedge clk);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!stall) done = 1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        check("done_reached", {31'b0, done}, 32'd1);
        check($sformatf("stall_cycles op%0d sc%0d", o, s), n, from_idle ? s[4:2] + 1 : {29'b0, s[4:2]});
        last = model(o, v, int'(s));
        check($sformatf("y op%0d x%08h sc%0d", o, v, s), y, last);
    endtask

    task automatic go_idle();
        run = 1'b0;
        @(negedge clk);
        #1;
        check("idle_stall", {31'b0, stall}, 32'd0);
        check("idle_hold", y, last);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_y", y, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        run = 1'b1;
        #1 check("rst_stall_run", {31'b0, stall}, 32'd0);
        run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        last = 32'h0;

        run_op(2'b00, 32'h00000001, 5'd31, 1); go_idle();
        check("lsl_const", last, 32'h80000000);
        run_op(2'b01, 32'h80000000, 5'd4, 1); go_idle();
        check("asr_const", y, 32'hF8000000);
        run_op(2'b01, 32'h7FFFFFFF, 5'd31, 1); go_idle();
        check("asr_pos_const", y, 32'h00000000);
        run_op(2'b10, 32'h12345678, 5'd8, 1); go_idle();
`ifdef ITER_SHIFTER_ROR_EN
        check("ror_const", y, 32'h78123456);
`else
        check("ror_const", y, 32'h00123456);
`endif
        for (int o = 0; o < 4; o++) begin
            run_op(o[1:0], 32'hDEADBEEF, 5'd0, 1); go_idle();
            check("sc0_const", y, 32'hDEADBEEF);
        end

        run_op(2'b00, 32'h3, 5'd5, 1);
        check("b2b_first", y, 32'h60);
        run_op(2'b00, 32'h3, 5'd2, 0);
        check("b2b_second", y, 32'hC);
        go_idle();

        op = 2'b00; x = 32'h1; sc = 5'd31; run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("midrst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        check("midrst_y", y, 32'h0);
        rst = 1'b0;
        run_op(2'b00, 32'h1, 5'd31, 1); go_idle();

        for (int i = 0; i < 60; i++) begin
            bit idle_start;
            idle_start = (i == 0) || $urandom_range(0, 1) == 1;
            if (idle_start && i != 0) go_idle();
            run_op(2'($urandom), $urandom, 5'($urandom), idle_start);
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
